// File: rtl/ifetch_if.sv
// Fetch-side bus bundle: the instruction-ROM read port plus the decode handshake.
// Handshake: a transfer happens on a rising edge where out_valid && out_ready; out_pc/out_insn must not change while out_valid && !out_ready.
interface ifetch_if #(
    parameter int WORD = 32,
    parameter int ADDR = 32
);
    logic [ADDR-1:0] imem_addr;
    logic [WORD-1:0] imem_dout;
    logic            out_valid;
    logic            out_ready;
    logic [ADDR-1:0] out_pc;
    logic [WORD-1:0] out_insn;

    modport master (
        output imem_addr,
        input  imem_dout,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_insn
    );

    modport slave (
        input  imem_addr,
        output imem_dout,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_insn
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: drives the ROM address and presents (pc, insn) to decode.
// Optional macro IFETCH_PERF_EN adds handshake/stall performance counters.
module ifetch #(
    parameter int              WORD     = 32,
    parameter int              ADDR     = 32,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    ifetch_if.master        bus,
    input  logic            fetch_en_i,
    input  logic            redirect_i,
    input  logic [ADDR-1:0] redirect_pc_i,
    output logic            fault_o,
    output logic [ADDR-1:0] fault_addr_o,
`ifdef IFETCH_PERF_EN
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_stall_o,
`endif
    output logic [1:0]      state_o
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [ADDR-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [ADDR-1:0] fault_addr_q, fault_addr_d;
    logic [ADDR-1:0] pc_inc;
    logic [ADDR-1:0] imem_addr;
    logic [WORD-1:0] insn;
    logic            out_valid;
    logic            redir_ok;

    assign pc_inc   = pc_q + ADDR'(4);
    assign redir_ok = (redirect_pc_i[1:0] == 2'b00);

    // Redirect dominates every state; otherwise the address is either the
    // next sequential PC (on accept) or a replay of pc_q.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        imem_addr    = pc_q;
        if (redirect_i) begin
            if (redir_ok) begin
                imem_addr = redirect_pc_i;
                pc_d      = redirect_pc_i;
                fault_d   = 1'b0;
                state_d   = fetch_en_i ? ST_RUN : ST_PAUSE;
            end else begin
                fault_addr_d = redirect_pc_i;
                fault_d      = 1'b1;
                state_d      = ST_FAULT;
            end
        end else begin
            case (state_q)
                ST_BOOT: state_d = fetch_en_i ? ST_RUN : ST_PAUSE;
                ST_RUN: begin
                    if (bus.out_ready) begin
                        imem_addr = pc_inc;
                        pc_d      = pc_inc;
                        state_d   = fetch_en_i ? ST_RUN : ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (fetch_en_i) state_d = ST_RUN;
                end
                default: state_d = ST_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign out_valid     = (state_q == ST_RUN) && !redirect_i;
    assign insn          = bus.imem_dout;
    assign bus.imem_addr = imem_addr;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = pc_q;
    assign bus.out_insn  = insn;
    assign fault_o       = fault_q;
    assign fault_addr_o  = fault_addr_q;
    assign state_o       = state_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (out_valid && bus.out_ready)  perf_fetched_q <= perf_fetched_q + 32'd1;
            if (out_valid && !bus.out_ready) perf_stall_q   <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the requester on the instruction-ROM read port. It drives a byte address to the instruction ROM, which returns the 32-bit little-endian word at that address registered one clock later, and presents each fetched word with its PC to the decode stage over a valid/ready handshake. It sits between the instruction ROM and decode. It handles sequential fetch, backpressure, pipeline redirects (branch/jump/trap), a fetch-enable pause and misaligned-redirect faults.

## Interface
- WORD, 32, instruction width
- ADDR, 32, byte-address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR  byte address to ROM, combinational from state/inputs
- imem_dout  in  WORD  ROM data, word at the imem_addr of the previous cycle
- fetch_en  in  1  fetch enable; sampled only at accept and in PAUSE/BOOT
- redirect  in  1  load new PC, highest priority
- redirect_pc  in  ADDR  redirect target
- out_valid  out  1  out_pc/out_insn valid
- out_ready  in  1  decode accepts
- out_pc  out  ADDR  PC of out_insn (= pc_q)
- out_insn  out  WORD  = imem_dout passthrough
- fault  out  1  misaligned redirect, sticky until cleared
- fault_addr  out  ADDR  offending redirect_pc

## Operation
- Register pc_q holds the address whose word is on imem_dout in RUN.
- FSM states: BOOT, RUN, PAUSE, FAULT.
- out_valid = (state==RUN) && !redirect.
- BOOT (reset state): imem_addr=pc_q. Next state is RUN if fetch_en, else PAUSE.
- RUN, no redirect:
  - out_ready=1, fetch_en=1: imem_addr=pc_q+4, pc_q<=pc_q+4, stay RUN.
  - out_ready=1, fetch_en=0: imem_addr=pc_q+4, pc_q<=pc_q+4, go PAUSE.
  - out_ready=0: imem_addr=pc_q (replay), hold; fetch_en ignored.
- PAUSE: imem_addr=pc_q, out_valid=0. When fetch_en=1, go RUN.
- Redirect, any state:
  - Aligned (redirect_pc[1:0]==0): imem_addr=redirect_pc, pc_q<=redirect_pc. Next state is RUN if fetch_en, else PAUSE.
  - Misaligned: pc_q unchanged, fault_addr<=redirect_pc, fault<=1, go FAULT.
- FAULT: out_valid=0, imem_addr=pc_q. Exit only via an aligned redirect, which clears fault. A misaligned redirect in FAULT updates fault_addr.
- Arithmetic: pc_q+4 is modulo 2^ADDR; 0xFFFF_FFFC wraps to 0. No ROM-size check.

## Timing
- Reset (rst=0): state=BOOT, pc_q=RESET_PC, imem_addr=RESET_PC, out_valid=0, out_pc=RESET_PC, fault=0, fault_addr=0, counters=0. out_insn follows imem_dout.
- After rst deasserts with fetch_en=1: BOOT for 1 cycle, then out_valid=1 with the word at RESET_PC.
- Throughput: 1 instruction/cycle while out_ready=1.
- Redirect→valid latency: 1 cycle. The cycle redirect is high shows out_valid=0. The next cycle shows the target word.
- Stall: out_pc/out_insn stable while out_valid=1 && out_ready=0, because the same address is replayed.
- Reset mid-operation: immediate return to the reset values. An in-flight handshake is lost.
- redirect and out_ready together: redirect wins. The current instruction is not accepted (out_valid=0).

## Configuration
- IFETCH_PERF_EN defined: adds two outputs, each 32-bit, wrapping, reset to 0.
  - perf_fetched counts handshakes (out_valid && out_ready).
  - perf_stall counts cycles with out_valid && !out_ready.
- IFETCH_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset release, RESET_PC=0, fetch_en=1, out_ready=1, ROM words 0..3 = A,B,C,D -> out_valid from cycle 2; (pc,insn) = (0,A),(4,B),(8,C),(C,D) on consecutive cycles.
- out_ready low for 3 cycles while showing (4,B) -> (4,B) held 3 cycles, imem_addr=4 throughout; then (8,C) follows. With PERF: perf_stall=3.
- redirect=1, redirect_pc=0x40 while showing (8,C) -> out_valid=0 that cycle, next cycle (0x40, word@0x40); PERF: perf_fetched excludes C.
- fetch_en=0 at accept of (0,A) -> PAUSE, out_valid=0, imem_addr=4; fetch_en=1 -> next cycle (4,B).
- redirect_pc=0x42 -> fault=1, fault_addr=0x42, out_valid=0; then redirect_pc=0x80 -> fault=0, (0x80, word) next cycle.
- pc_q=0xFFFF_FFFC accepted -> next out_pc=0; async rst pulse mid-stream -> outputs at reset values within the same cycle.
